// File: rtl/aq_gemac_arp_cache_pkg.sv
// Shared types for the L3 ARP cache: FSM states, operation kind, binding payload.
package aq_gemac_arp_cache_pkg;

  localparam int unsigned IP_W  = 32;
  localparam int unsigned MAC_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AGE    = 2'd1,
    ST_SCAN   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_LEARN  = 1'b1
  } op_e;

  typedef struct packed {
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
  } arp_bind_t;

endpackage

// File: rtl/aq_gemac_arp_table.sv
// ARP entry flop array: one async indexed read port, one write port,
// a broadcast aging strobe and the packed valid vector.
module aq_gemac_arp_table
  import aq_gemac_arp_cache_pkg::*;
#(
  parameter int unsigned            ENTRIES = 8,
  parameter int unsigned            AGE_W   = 8,
  parameter logic [AGE_W-1:0]       AGE_MAX = AGE_W'(200),
  localparam int unsigned           IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_c_o,
  output logic [IP_W-1:0]    rd_ip_c_o,
  output logic [MAC_W-1:0]   rd_mac_c_o,
  output logic [AGE_W-1:0]   rd_age_c_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [IP_W-1:0]    wr_ip_i,
  input  logic [MAC_W-1:0]   wr_mac_i,
  input  logic               age_stb_i,
  output logic [ENTRIES-1:0] valid_o
);

  logic [ENTRIES-1:0] valid_q;
  arp_bind_t          bind_q [ENTRIES];
  logic [AGE_W-1:0]   age_q  [ENTRIES];

  // Entry storage: aging strobe and write are never active in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        bind_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (age_stb_i) begin
          if (valid_q[i]) begin
            if (age_q[i] == AGE_MAX) begin
              valid_q[i] <= 1'b0;
            end else begin
              age_q[i] <= age_q[i] + AGE_W'(1);
            end
          end
        end else if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          valid_q[i] <= 1'b1;
          bind_q[i]  <= '{ip: wr_ip_i, mac: wr_mac_i};
          age_q[i]   <= '0;
        end
      end
    end
  end

  assign rd_valid_c_o = valid_q[rd_idx_i];
  assign rd_ip_c_o    = bind_q[rd_idx_i].ip;
  assign rd_mac_c_o   = bind_q[rd_idx_i].mac;
  assign rd_age_c_o   = age_q[rd_idx_i];
  assign valid_o      = valid_q;

endmodule

// File: rtl/aq_gemac_arp_cache.sv
// ARP cache beside the L3 controller: learns IP->MAC bindings, answers lookups
// after a full fixed-length table scan, and ages entries on a periodic tick.
module aq_gemac_arp_cache
  import aq_gemac_arp_cache_pkg::*;
#(
  parameter int unsigned      ENTRIES = 8,
  parameter int unsigned      AGE_W   = 8,
  parameter logic [AGE_W-1:0] AGE_MAX = AGE_W'(200),
  localparam int unsigned     IDX_W   = $clog2(ENTRIES),
  localparam int unsigned     CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ARPC_ENABLE,
  input  logic              LEARN_VALID,
  input  logic [31:0]       LEARN_IP,
  input  logic [47:0]       LEARN_MAC,
  input  logic              ARPC_REQUEST,
  input  logic [31:0]       ARPC_IP_ADDRESS,
  output logic              READY,
  output logic              ARPC_VALID,
  output logic              ARPC_HIT,
  output logic [47:0]       ARPC_MAC_ADDRESS,
  input  logic              AGE_TICK,
  output logic [CNT_W-1:0]  ENTRY_COUNT
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [IP_W-1:0]    ip_q, ip_d;
  logic [MAC_W-1:0]   mac_q, mac_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic               match_found_q, match_found_d;
  logic [IDX_W-1:0]   match_idx_q, match_idx_d;
  logic [MAC_W-1:0]   match_mac_q, match_mac_d;
  logic               inv_found_q, inv_found_d;
  logic [IDX_W-1:0]   inv_idx_q, inv_idx_d;
  logic               old_found_q, old_found_d;
  logic [IDX_W-1:0]   old_idx_q, old_idx_d;
  logic [AGE_W-1:0]   old_age_q, old_age_d;
  logic               age_pending_q, age_pending_d;
  logic               ready_q, ready_d;
  logic               arpc_valid_q, arpc_valid_d;
  logic               arpc_hit_q, arpc_hit_d;
  logic [MAC_W-1:0]   arpc_mac_q, arpc_mac_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               rd_valid;
  logic [IP_W-1:0]    rd_ip;
  logic [MAC_W-1:0]   rd_mac;
  logic [AGE_W-1:0]   rd_age;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               age_stb;
  logic [ENTRIES-1:0] valid_vec;
  logic               accept;
  logic               hit_now;

  assign READY  = ready_q & ARPC_ENABLE;
  assign accept = READY & (LEARN_VALID | ARPC_REQUEST);

  aq_gemac_arp_table #(
    .ENTRIES (ENTRIES),
    .AGE_W   (AGE_W),
    .AGE_MAX (AGE_MAX)
  ) u_table (
    .clk_i        (CLK),
    .rst_i        (RST),
    .rd_idx_i     (scan_idx_q),
    .rd_valid_c_o (rd_valid),
    .rd_ip_c_o    (rd_ip),
    .rd_mac_c_o   (rd_mac),
    .rd_age_c_o   (rd_age),
    .wr_en_i      (wr_en),
    .wr_idx_i     (wr_idx),
    .wr_ip_i      (ip_q),
    .wr_mac_i     (mac_q),
    .age_stb_i    (age_stb),
    .valid_o      (valid_vec)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, scan bookkeeping, table control and registered outputs.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ip_d          = ip_q;
    mac_d         = mac_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    match_mac_d   = match_mac_q;
    inv_found_d   = inv_found_q;
    inv_idx_d     = inv_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    arpc_valid_d  = 1'b0;
    arpc_hit_d    = arpc_hit_q;
    arpc_mac_d    = arpc_mac_q;
    wr_en         = 1'b0;
    wr_idx        = old_idx_q;
    age_stb       = 1'b0;
    age_pending_d = AGE_TICK | (age_pending_q & (state_q != ST_AGE));
    hit_now       = rd_valid & (rd_ip == ip_q) & (ip_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (age_pending_q) begin
          state_d = ST_AGE;
        end else if (accept) begin
          op_d          = LEARN_VALID ? OP_LEARN : OP_LOOKUP;
          ip_d          = LEARN_VALID ? LEARN_IP : ARPC_IP_ADDRESS;
          mac_d         = LEARN_MAC;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          inv_found_d   = 1'b0;
          old_found_d   = 1'b0;
          state_d       = ST_SCAN;
        end
      end
      ST_AGE: begin
        age_stb = 1'b1;
        state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (hit_now && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
          match_mac_d   = rd_mac;
        end
        if (!rd_valid && !inv_found_q) begin
          inv_found_d = 1'b1;
          inv_idx_d   = scan_idx_q;
        end
        // Strictly-greater keeps the lowest index on age ties.
        if (rd_valid && (!old_found_q || (rd_age > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = scan_idx_q;
          old_age_d   = rd_age;
        end
        if (scan_idx_q == IDX_W'(ENTRIES - 1)) begin
          state_d = ST_COMMIT;
          if (op_q == OP_LOOKUP) begin
            arpc_valid_d = 1'b1;
            arpc_hit_d   = match_found_d;
            arpc_mac_d   = match_found_d ? match_mac_d : '0;
          end
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        // Refresh a match, else fill a hole, else evict the oldest.
        if ((op_q == OP_LEARN) && (ip_q != '0)) begin
          wr_en = 1'b1;
          if (match_found_q) begin
            wr_idx = match_idx_q;
          end else if (inv_found_q) begin
            wr_idx = inv_idx_q;
          end
        end
        // A tick that landed during the operation is serviced straight away.
        state_d = age_pending_q ? ST_AGE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) & ~age_pending_d;

    count_d = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      count_d = count_d + CNT_W'(valid_vec[i]);
    end
  end

  // Operation context, scan results and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q          <= OP_LOOKUP;
      ip_q          <= '0;
      mac_q         <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      match_mac_q   <= '0;
      inv_found_q   <= 1'b0;
      inv_idx_q     <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      age_pending_q <= 1'b0;
      ready_q       <= 1'b0;
      arpc_valid_q  <= 1'b0;
      arpc_hit_q    <= 1'b0;
      arpc_mac_q    <= '0;
      count_q       <= '0;
    end else begin
      op_q          <= op_d;
      ip_q          <= ip_d;
      mac_q         <= mac_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      match_mac_q   <= match_mac_d;
      inv_found_q   <= inv_found_d;
      inv_idx_q     <= inv_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      age_pending_q <= age_pending_d;
      ready_q       <= ready_d;
      arpc_valid_q  <= arpc_valid_d;
      arpc_hit_q    <= arpc_hit_d;
      arpc_mac_q    <= arpc_mac_d;
      count_q       <= count_d;
    end
  end

  assign ARPC_VALID       = arpc_valid_q;
  assign ARPC_HIT         = arpc_hit_q;
  assign ARPC_MAC_ADDRESS = arpc_mac_q;
  assign ENTRY_COUNT      = count_q;

endmodule

// File: tb/tb_aq_gemac_arp_cache.sv
// Self-checking bench for aq_gemac_arp_cache (ENTRIES=4, AGE_MAX=2):
// vector table for learn/lookup basics, hand sequences for timing corners.
module tb_aq_gemac_arp_cache;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned CNT_W   = $clog2(ENTRIES + 1);

  localparam logic [31:0] IP_A = 32'hC0A80102;   // 192.168.1.2
  localparam logic [31:0] IP_X = 32'h0A000009;   // 10.0.0.9
  localparam logic [47:0] MAC1 = 48'h001122334455;
  localparam logic [47:0] MAC2 = 48'h66778899AABB;
  localparam logic [47:0] MAC3 = 48'hDEADBEEF0001;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ARPC_ENABLE = 1'b1;
  logic             LEARN_VALID = 1'b0;
  logic [31:0]      LEARN_IP = '0;
  logic [47:0]      LEARN_MAC = '0;
  logic             ARPC_REQUEST = 1'b0;
  logic [31:0]      ARPC_IP_ADDRESS = '0;
  logic             READY;
  logic             ARPC_VALID;
  logic             ARPC_HIT;
  logic [47:0]      ARPC_MAC_ADDRESS;
  logic             AGE_TICK = 1'b0;
  logic [CNT_W-1:0] ENTRY_COUNT;

  aq_gemac_arp_cache #(
    .ENTRIES (ENTRIES),
    .AGE_W   (8),
    .AGE_MAX (8'd2)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .ARPC_ENABLE      (ARPC_ENABLE),
    .LEARN_VALID      (LEARN_VALID),
    .LEARN_IP         (LEARN_IP),
    .LEARN_MAC        (LEARN_MAC),
    .ARPC_REQUEST     (ARPC_REQUEST),
    .ARPC_IP_ADDRESS  (ARPC_IP_ADDRESS),
    .READY            (READY),
    .ARPC_VALID       (ARPC_VALID),
    .ARPC_HIT         (ARPC_HIT),
    .ARPC_MAC_ADDRESS (ARPC_MAC_ADDRESS),
    .AGE_TICK         (AGE_TICK),
    .ENTRY_COUNT      (ENTRY_COUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        hit;
    logic [47:0] mac;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        learn;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        hit;
    logic [47:0] exp_mac;
    int          cnt;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: compare any lookup result against the scoreboard head.
  task automatic sb_sample();
    exp_t e;
    if (ARPC_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("lookup_hit", 64'(ARPC_HIT), 64'(e.hit));
        check("lookup_mac", 64'(ARPC_MAC_ADDRESS), 64'(e.mac));
        check("lookup_latency", 64'(cyc), 64'(e.due));
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (READY !== 1'b1 && n < 40) begin
      @(negedge CLK);
      sb_sample();
      n++;
    end
    if (READY !== 1'b1) check({name, "_ready_timeout"}, 64'(0), 64'(1));
  endtask

  // One request from idle; returns two cycles after COMMIT so ENTRY_COUNT has settled.
  task automatic run_op(input logic learn, input logic [31:0] ip, input logic [47:0] mac,
                        input logic ehit, input logic [47:0] emac);
    wait_ready("op");
    if (learn) begin
      LEARN_VALID = 1'b1;
      LEARN_IP    = ip;
      LEARN_MAC   = mac;
    end else begin
      ARPC_REQUEST    = 1'b1;
      ARPC_IP_ADDRESS = ip;
      sb.push_back('{hit: ehit, mac: emac, due: cyc + 5});
    end
    @(negedge CLK);
    LEARN_VALID  = 1'b0;
    ARPC_REQUEST = 1'b0;
    sb_sample();
    repeat (6) begin
      @(negedge CLK);
      sb_sample();
    end
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    LEARN_VALID  = 1'b0;
    ARPC_REQUEST = 1'b0;
    AGE_TICK     = 1'b0;
    sb.delete();
    repeat (3) @(negedge CLK);
    check("rst_ready", 64'(READY), 64'(0));
    check("rst_valid", 64'(ARPC_VALID), 64'(0));
    check("rst_hit", 64'(ARPC_HIT), 64'(0));
    check("rst_mac", 64'(ARPC_MAC_ADDRESS), 64'(0));
    check("rst_count", 64'(ENTRY_COUNT), 64'(0));
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 64'(READY), 64'(1));
  endtask

  // Tick from idle: READY low for the pending-idle cycle and the AGE cycle.
  task automatic tick_idle();
    wait_ready("tick");
    AGE_TICK = 1'b1;
    @(negedge CLK);
    AGE_TICK = 1'b0;
    check("tick_pending_ready", 64'(READY), 64'(0));
    @(negedge CLK);
    check("tick_age_ready", 64'(READY), 64'(0));
    @(negedge CLK);
    check("tick_done_ready", 64'(READY), 64'(1));
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int acc;
    int nvalid;
    logic got;

    vecs[0] = '{1'b0, IP_X,  48'h0, 1'b0, 48'h0, 0};
    vecs[1] = '{1'b1, 32'h0, MAC1,  1'b0, 48'h0, 0};
    vecs[2] = '{1'b0, 32'h0, 48'h0, 1'b0, 48'h0, 0};
    vecs[3] = '{1'b1, IP_A,  MAC1,  1'b0, 48'h0, 1};
    vecs[4] = '{1'b0, IP_A,  48'h0, 1'b1, MAC1,  1};
    vecs[5] = '{1'b1, IP_A,  MAC2,  1'b0, 48'h0, 1};
    vecs[6] = '{1'b0, IP_A,  48'h0, 1'b1, MAC2,  1};
    vecs[7] = '{1'b1, IP_X,  MAC3,  1'b0, 48'h0, 2};
    vecs[8] = '{1'b0, IP_X,  48'h0, 1'b1, MAC3,  2};
    vecs[9] = '{1'b0, IP_A,  48'h0, 1'b1, MAC2,  2};

    // Basic learn / lookup / miss / IP 0 / refresh.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].learn, vecs[i].ip, vecs[i].mac, vecs[i].hit, vecs[i].exp_mac);
      check($sformatf("vec%0d_count", i), 64'(ENTRY_COUNT), 64'(vecs[i].cnt));
    end
    check("mac_held", 64'(ARPC_MAC_ADDRESS), 64'(MAC2));

    // Eviction: A..D aged once, B and C refreshed, E replaces A.
    do_reset();
    for (int i = 1; i <= 4; i++) run_op(1'b1, 32'h0A000000 + 32'(i), 48'h0000000A0000 + 48'(i), 1'b0, 48'h0);
    check("fill_count", 64'(ENTRY_COUNT), 64'(4));
    tick_idle();
    run_op(1'b1, 32'h0A000002, 48'h0000000A0002, 1'b0, 48'h0);
    run_op(1'b1, 32'h0A000003, 48'h0000000A0003, 1'b0, 48'h0);
    run_op(1'b1, 32'h0A000005, 48'h0000000A0005, 1'b0, 48'h0);
    check("evict_count", 64'(ENTRY_COUNT), 64'(4));
    run_op(1'b0, 32'h0A000001, 48'h0, 1'b0, 48'h0);
    run_op(1'b0, 32'h0A000005, 48'h0, 1'b1, 48'h0000000A0005);
    run_op(1'b0, 32'h0A000004, 48'h0, 1'b1, 48'h0000000A0004);
    run_op(1'b0, 32'h0A000002, 48'h0, 1'b1, 48'h0000000A0002);

    // Aging: AGE_MAX=2, so the third tick invalidates.
    do_reset();
    run_op(1'b1, IP_A, MAC1, 1'b0, 48'h0);
    tick_idle();
    check("age1_count", 64'(ENTRY_COUNT), 64'(1));
    repeat (3) @(negedge CLK);
    tick_idle();
    check("age2_count", 64'(ENTRY_COUNT), 64'(1));
    repeat (3) @(negedge CLK);
    tick_idle();
    check("age3_count", 64'(ENTRY_COUNT), 64'(0));
    run_op(1'b0, IP_A, 48'h0, 1'b0, 48'h0);

    // Tick during a scan: one extra READY-low cycle after COMMIT.
    run_op(1'b1, IP_A, MAC1, 1'b0, 48'h0);
    wait_ready("tick_scan");
    c0 = cyc;
    ARPC_REQUEST    = 1'b1;
    ARPC_IP_ADDRESS = IP_A;
    sb.push_back('{hit: 1'b1, mac: MAC1, due: c0 + 5});
    @(negedge CLK);
    ARPC_REQUEST = 1'b0;
    sb_sample();
    @(negedge CLK);
    sb_sample();
    AGE_TICK = 1'b1;
    @(negedge CLK);
    AGE_TICK = 1'b0;
    sb_sample();
    repeat (2) begin
      @(negedge CLK);
      sb_sample();
    end
    check("tick_scan_commit_ready", 64'(READY), 64'(0));
    @(negedge CLK);
    sb_sample();
    check("tick_scan_age_ready", 64'(READY), 64'(0));
    @(negedge CLK);
    check("tick_scan_ready_back", 64'(READY), 64'(1));
    check("tick_scan_cycle", 64'(cyc - c0), 64'(7));
    check("tick_scan_drained", 64'(sb.size()), 64'(0));

    // Learn and lookup together, tick mid-scan: lookup accepted at cycle 7.
    wait_ready("both");
    c0 = cyc;
    LEARN_VALID     = 1'b1;
    LEARN_IP        = 32'h0A000002;
    LEARN_MAC       = MAC3;
    ARPC_REQUEST    = 1'b1;
    ARPC_IP_ADDRESS = IP_A;
    @(negedge CLK);
    LEARN_VALID = 1'b0;
    sb_sample();
    got = 1'b0;
    acc = -1;
    for (int n = 2; n < 30 && !got; n++) begin
      @(negedge CLK);
      sb_sample();
      AGE_TICK = (n == 2);
      if (READY === 1'b1) begin
        got = 1'b1;
        acc = cyc - c0;
      end
    end
    AGE_TICK = 1'b0;
    check("both_lookup_accept_cycle", 64'(acc), 64'(7));
    sb.push_back('{hit: 1'b1, mac: MAC1, due: cyc + 5});
    @(negedge CLK);
    ARPC_REQUEST = 1'b0;
    sb_sample();
    repeat (6) begin
      @(negedge CLK);
      sb_sample();
    end
    check("both_drained", 64'(sb.size()), 64'(0));
    check("both_count", 64'(ENTRY_COUNT), 64'(2));

    // Reset during SCAN cycle 2: no response, table cleared.
    wait_ready("rst_scan");
    ARPC_REQUEST    = 1'b1;
    ARPC_IP_ADDRESS = IP_A;
    @(negedge CLK);
    ARPC_REQUEST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    nvalid = 0;
    @(negedge CLK);
    if (ARPC_VALID === 1'b1) nvalid++;
    RST = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (ARPC_VALID === 1'b1) nvalid++;
    end
    check("rst_scan_no_valid", 64'(nvalid), 64'(0));
    check("rst_scan_count", 64'(ENTRY_COUNT), 64'(0));
    check("rst_scan_mac", 64'(ARPC_MAC_ADDRESS), 64'(0));
    run_op(1'b0, IP_A, 48'h0, 1'b0, 48'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
